// File: rtl/fdivsqrt_uotfc2_if.sv
// rtl/fdivsqrt_uotfc2_if.sv - control, digit and root/mask buses of the on-the-fly converter
interface fdivsqrt_uotfc2_if #(
  parameter int DIVb = 26,
  parameter int CNTW = 6
);
  localparam int W = DIVb + 4;

  logic            start;
  logic            kill;
  logic            step;
  logic            up;
  logic            uz;
  logic [CNTW-1:0] nIter;
  logic [W-1:0]    U0;
  logic [W-1:0]    UM0;
  logic [W-1:0]    C0;
  logic [W-1:0]    U;
  logic [W-1:0]    UM;
  logic [W-1:0]    C;
  logic            busy;
  logic            done;

  modport master (
    output start, kill, step, up, uz, nIter, U0, UM0, C0,
    input  U, UM, C, busy, done
  );

  modport slave (
    input  start, kill, step, up, uz, nIter, U0, UM0, C0,
    output U, UM, C, busy, done
  );
endinterface

// File: rtl/fdivsqrt_uotfc2.sv
// rtl/fdivsqrt_uotfc2.sv - radix-2 on-the-fly root/quotient converter (U, UM, C) with run sequencing
module fdivsqrt_uotfc2 #(
  parameter int DIVb = 26,
  parameter int CNTW = 6
) (
  input logic             clk,
  input logic             reset,
  fdivsqrt_uotfc2_if.slave bus
);
  localparam int W = DIVb + 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    u_q;
  logic [W-1:0]    um_q;
  logic [W-1:0]    c_q;
  logic [W-1:0]    cn;
  logic [W-1:0]    k;
  logic [CNTW-1:0] cnt_q;
  logic            load;
  logic            iter;
  logic            sat;

  // kill beats start, and a start in RUN restarts rather than iterating
  assign load = bus.start && !bus.kill;
  assign iter = (state == RUN) && bus.step && !bus.kill && !bus.start;

  assign cn  = {c_q[W-1], c_q[W-1:1]};
  assign k   = cn & ~(cn << 1);
  // an all-ones mask has no digit position left, so the root is frozen
  assign sat = &c_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.kill) begin
      state_nxt = IDLE;
    end else if (bus.start) begin
      state_nxt = RUN;
    end else begin
      case (state)
        RUN:     if (bus.step && cnt_q == CNTW'(1)) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state)
      RUN:     bus.busy = 1'b1;
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      u_q   <= '0;
      um_q  <= '0;
      c_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      u_q   <= bus.U0;
      um_q  <= bus.UM0;
      c_q   <= bus.C0;
      cnt_q <= bus.nIter;
    end else if (iter) begin
      c_q   <= cn;
      cnt_q <= cnt_q - CNTW'(1);
      if (!sat) begin
        if (bus.up) begin
          u_q  <= u_q | k;
          um_q <= u_q;
        end else if (bus.uz) begin
          um_q <= um_q | k;
        end else begin
          u_q  <= um_q | k;
        end
      end
    end
  end

  assign bus.U  = u_q;
  assign bus.UM = um_q;
  assign bus.C  = c_q;
endmodule
